// File: rtl/pe_result_collector_pkg.sv
// Shared defaults and FSM encoding for the PE result collector.
package pe_result_collector_pkg;

  localparam int unsigned DefDataWidth      = 32;
  localparam int unsigned DefPipelineStages = 12;
  localparam int unsigned DefBufferWidth    = 5;
  localparam int unsigned DefCountWidth     = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } collector_state_e;

endpackage

// File: rtl/collector_fifo.sv
// Single-clock first-word-fall-through FIFO holding collected PE results.
module collector_fifo
  import pe_result_collector_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddrWidth = DefBufferWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] pop_data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [AddrWidth:0]   count_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth:0] DepthCnt = (AddrWidth + 1)'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   count_q;
  logic                 wr_en, rd_en;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DepthCnt);
  assign rd_en      = pop_i & ~empty_o;
  // A full FIFO still accepts a word when the head is freed in the same cycle.
  assign wr_en      = push_i & (~full_o | rd_en);
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pe_result_collector.sv
// Credit-based sink for the PE chain O-stream: grants issue slots, buffers
// results and tracks a host-programmed frame length.
module pe_result_collector
  import pe_result_collector_pkg::*;
#(
  parameter int unsigned DataWidth       = DefDataWidth,
  parameter int unsigned Pipeline_Stages = DefPipelineStages,
  parameter int unsigned BufferWidth     = DefBufferWidth,
  parameter int unsigned BufferSize      = 2 ** BufferWidth,
  parameter int unsigned CountWidth      = DefCountWidth
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  clk_en,
  input  logic [DataWidth-1:0]  O_DataIn,
  input  logic                  O_DataInValid,
  output logic                  O_DataInRdy,
  input  logic                  start,
  input  logic [CountWidth-1:0] cfg_count,
  input  logic                  rd_en,
  output logic [DataWidth-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [BufferWidth:0]  occupancy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned SumWidth = BufferWidth + 2;

  collector_state_e           state_q;
  logic [CountWidth-1:0]      cfg_q, rx_cnt_q, rd_cnt_q, issued_q;
  logic [Pipeline_Stages-1:0] cr_q;
  logic                       overflow_q;

  logic                push, pop, fifo_empty, fifo_full, drop;
  logic [SumWidth-1:0] pending, credit_sum;
  logic                credit_ok, issue_limit;

  assign push = clk_en & O_DataInValid;
  assign pop  = clk_en & rd_en & rd_valid;
  assign drop = push & fifo_full & ~pop;

  collector_fifo #(
    .DataWidth (DataWidth),
    .AddrWidth (BufferWidth)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (aclr),
    .push_i      (push),
    .push_data_i (O_DataIn),
    .pop_i       (pop),
    .pop_data_o  (rd_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (occupancy)
  );

  // Grants from the last Pipeline_Stages cycles are results still in the PE pipe.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < Pipeline_Stages; i++) begin
      pending = pending + SumWidth'(cr_q[i]);
    end
  end

  // Pops are ignored here so the credit is conservative.
  assign credit_sum  = SumWidth'(occupancy) + pending + SumWidth'(1);
  assign credit_ok   = (credit_sum <= SumWidth'(BufferSize));
  assign issue_limit = (cfg_q != '0) && (issued_q >= cfg_q);

  assign O_DataInRdy = (state_q == StCollect) && credit_ok && !issue_limit;
  assign rd_valid    = ~fifo_empty;
  assign frame_done  = (state_q == StDone);
  assign overflow    = overflow_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q    <= StIdle;
      cfg_q      <= '0;
      rx_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      issued_q   <= '0;
      cr_q       <= '0;
      overflow_q <= 1'b0;
    end else if (clk_en) begin
      cr_q     <= {cr_q[Pipeline_Stages-2:0], O_DataInRdy};
      rx_cnt_q <= rx_cnt_q + CountWidth'(push);
      rd_cnt_q <= rd_cnt_q + CountWidth'(pop);
      if (O_DataInRdy) issued_q <= issued_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      if (start) begin
        // Traffic in the start cycle already belongs to the new frame.
        cfg_q      <= cfg_count;
        rx_cnt_q   <= CountWidth'(push);
        rd_cnt_q   <= CountWidth'(pop);
        issued_q   <= '0;
        cr_q       <= '0;
        overflow_q <= drop;
        state_q    <= StCollect;
      end else begin
        case (state_q)
          StCollect: if (cfg_q != '0 && rx_cnt_q == cfg_q) state_q <= StDrain;
          StDrain:   if (rd_cnt_q == cfg_q) state_q <= StDone;
          default:   state_q <= state_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench: a PE pipe model answers each grant 12 cycles later with a
// random word; a monitor checks every popped word against the expected queue.
module tb_pe_result_collector;

  localparam int unsigned Lat   = 12;
  localparam int unsigned Depth = 32;

  logic        clk = 1'b0;
  logic        aclr, clk_en, O_DataInValid, O_DataInRdy, start, rd_en;
  logic        rd_valid, frame_done, overflow;
  logic [31:0] O_DataIn, rd_data;
  logic [15:0] cfg_count;
  logic [5:0]  occupancy;

  pe_result_collector dut (
    .clk           (clk),
    .aclr          (aclr),
    .clk_en        (clk_en),
    .O_DataIn      (O_DataIn),
    .O_DataInValid (O_DataInValid),
    .O_DataInRdy   (O_DataInRdy),
    .start         (start),
    .cfg_count     (cfg_count),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .occupancy     (occupancy),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } flight_t;

  flight_t     flight[$];
  logic [31:0] sb[$];
  int unsigned cyc, n_vec, n_err, grants, n_popped, m_cfg, m_issued;
  bit          m_ovf, active;
  int          pop_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdy", 64'(O_DataInRdy), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
  endtask

  // One clock of stimulus: check state left by the previous edge, then drive the next.
  task automatic step(input bit do_start, input logic [15:0] cfg, input bit do_force);
    bit          exp_rdy, valid, will_pop, rd_en_v;
    logic [31:0] word;
    int unsigned size;
    flight_t     f;
    @(negedge clk);
    cyc++;
    size = sb.size();
    chk("occupancy", 64'(occupancy), 64'(size));
    chk("rd_valid", 64'(rd_valid), 64'(size != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    exp_rdy = active && (size + flight.size() + 1 <= Depth) && (m_cfg == 0 || m_issued < m_cfg);
    chk("O_DataInRdy", 64'(O_DataInRdy), 64'(exp_rdy));
    if (O_DataInRdy) begin
      f.due  = cyc + Lat;
      f.data = $urandom;
      flight.push_back(f);
      m_issued++;
      grants++;
    end
    valid = 1'b0;
    word  = '0;
    if (flight.size() != 0 && flight[0].due == cyc) begin
      f     = flight.pop_front();
      valid = 1'b1;
      word  = f.data;
    end else if (do_force) begin
      valid = 1'b1;
      word  = $urandom;
    end
    rd_en_v  = (pop_mode == 1) || (pop_mode == 2 && $urandom_range(3) != 0);
    will_pop = rd_en_v && size != 0;
    if (do_start) begin
      m_ovf    = 1'b0;
      m_cfg    = cfg;
      m_issued = 0;
      active   = 1'b1;
    end
    if (valid) begin
      if (size == Depth && !will_pop) m_ovf = 1'b1;
      else sb.push_back(word);
    end
    O_DataIn      = word;
    O_DataInValid = valid;
    rd_en         = rd_en_v;
    start         = do_start;
    cfg_count     = cfg;
    #2;
  endtask

  task automatic do_reset(input bit expect_five);
    @(negedge clk);
    O_DataInValid = 1'b0;
    rd_en         = 1'b0;
    start         = 1'b0;
    if (expect_five) chk("pre_reset_occupancy", 64'(occupancy), 64'd5);
    #2 aclr = 1'b0;
    #1 chk_reset_outputs();
    sb.delete();
    flight.delete();
    m_ovf    = 1'b0;
    active   = 1'b0;
    m_cfg    = 0;
    m_issued = 0;
    @(negedge clk);
    aclr = 1'b1;
  endtask

  // Monitor: every accepted pop must return the oldest expected word.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (aclr && rd_en && rd_valid) begin
        if (sb.size() == 0) begin
          chk("pop_without_expected_word", 64'(rd_valid), 64'd0);
        end else begin
          exp = sb.pop_front();
          chk("rd_data", 64'(rd_data), 64'(exp));
          n_popped++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    aclr = 1'b0; clk_en = 1'b1; O_DataIn = '0; O_DataInValid = 1'b0;
    start = 1'b0; cfg_count = '0; rd_en = 1'b0; pop_mode = 0;
    @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    aclr = 1'b1;

    // Frame of 4 with continuous pops.
    pop_mode = 1; grants = 0; n_popped = 0;
    step(1'b1, 16'd4, 1'b0);
    for (int i = 0; i < 60 && n_popped < 4; i++) step(1'b0, 16'd0, 1'b0);
    chk("frame_done_early", 64'(frame_done), 64'd0);
    w = 0;
    while (!frame_done && w < 4) begin
      step(1'b0, 16'd0, 1'b0);
      w++;
    end
    chk("frame_done_latency", 64'(w), 64'd2);
    chk("frame1_grants", 64'(grants), 64'd4);
    chk("frame1_popped", 64'(n_popped), 64'd4);

    // Unbounded frame, no pops: credit must stop at exactly a full FIFO.
    pop_mode = 0; grants = 0;
    step(1'b1, 16'd0, 1'b0);
    repeat (70) step(1'b0, 16'd0, 1'b0);
    chk("fill_grants", 64'(grants), 64'd32);
    chk("fill_occupancy", 64'(occupancy), 64'd32);
    chk("fill_overflow", 64'(overflow), 64'd0);

    // Start popping: grants must resume, all words in order.
    pop_mode = 1;
    repeat (40) step(1'b0, 16'd0, 1'b0);
    pop_mode = 2;
    repeat (60) step(1'b0, 16'd0, 1'b0);
    chk("regrant", 64'(grants > 32), 64'd1);
    pop_mode = 0;
    for (int i = 0; i < 120 && !(sb.size() == Depth && flight.size() == 0); i++)
      step(1'b0, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    chk("refill_occupancy", 64'(occupancy), 64'd32);

    // Forced result into a full FIFO, then push+pop at full.
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b0);
    chk("overflow_set", 64'(overflow), 64'd1);
    pop_mode = 1;
    step(1'b0, 16'd0, 1'b1);
    pop_mode = 0;
    step(1'b0, 16'd0, 1'b0);
    chk("full_pushpop_occupancy", 64'(occupancy), 64'd32);
    step(1'b1, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    chk("overflow_cleared", 64'(overflow), 64'd0);

    // Drain with random extra pushes; wraps pointers and hits push+pop at occupancy 1.
    pop_mode = 1;
    repeat (120) step(1'b0, 16'd0, 1'($urandom_range(1)));
    repeat (30) step(1'b0, 16'd0, 1'b0);

    // Asynchronous reset mid-collect with 5 words stored.
    do_reset(1'b0);
    pop_mode = 0;
    step(1'b1, 16'd8, 1'b0);
    for (int i = 0; i < 60 && sb.size() < 5; i++) step(1'b0, 16'd0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
